// File: rtl/simple_processor_pkg.sv
// rtl/simple_processor_pkg.sv - shared constants and opcode type for the simple processor
package simple_processor_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    AND   = 4'd2,
    OR    = 4'd3,
    XOR   = 4'd4,
    SLL   = 4'd5,
    SRL   = 4'd6,
    SLT   = 4'd7,
    LOAD  = 4'd8,
    STORE = 4'd9
  } func_t;

endpackage

// File: rtl/alu_mem_stats.sv
// rtl/alu_mem_stats.sv - load/store access counters and sticky illegal-request flag
module alu_mem_stats #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ld_i,
  input  logic                 st_i,
  input  logic                 ill_i,
  output logic [CNT_WIDTH-1:0] ld_cnt_o,
  output logic [CNT_WIDTH-1:0] st_cnt_o,
  output logic                 illegal_sticky_o
);

  logic [CNT_WIDTH-1:0] r_ld_cnt;
  logic [CNT_WIDTH-1:0] r_st_cnt;
  logic                 r_sticky;

  // Counters wrap naturally; a reset edge discards any pending increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ld_cnt <= '0;
      r_st_cnt <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (ld_i)  r_ld_cnt <= r_ld_cnt + 1'b1;
      if (st_i)  r_st_cnt <= r_st_cnt + 1'b1;
      if (ill_i) r_sticky <= 1'b1;
    end
  end

  assign ld_cnt_o         = r_ld_cnt;
  assign st_cnt_o         = r_st_cnt;
  assign illegal_sticky_o = r_sticky;

endmodule

// File: rtl/alu_mem.sv
// rtl/alu_mem.sv - combinational load/store datapath with registered access statistics
module alu_mem
  import simple_processor_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  func_t                 func_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  we_i,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  output logic                  illegal_o,
  output logic                  illegal_sticky_o,
  output logic [CNT_WIDTH-1:0]  ld_cnt_o,
  output logic [CNT_WIDTH-1:0]  st_cnt_o
);

  logic w_is_load;
  logic w_is_store;

  assign w_is_load  = (func_i == LOAD);
  assign w_is_store = (func_i == STORE);

  assign mem_addr_o = rs1_data_i;

  // Data selection follows the opcode only; a mismatched we_i still routes data.
  always_comb begin
    mem_data_o = '0;
    if (w_is_load)       mem_data_o = rd_data_i;
    else if (w_is_store) mem_data_o = rs2_data_i;
  end

  assign mem_we_o  = w_is_store && we_i;
  assign mem_re_o  = w_is_load && !we_i;
  assign illegal_o = (w_is_load && we_i) || (w_is_store && !we_i);

  alu_mem_stats #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stats (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .ld_i            (mem_re_o),
    .st_i            (mem_we_o),
    .ill_i           (illegal_o),
    .ld_cnt_o        (ld_cnt_o),
    .st_cnt_o        (st_cnt_o),
    .illegal_sticky_o(illegal_sticky_o)
  );

endmodule

// File: tb/tb_alu_mem.sv
// tb/tb_alu_mem.sv - scoreboard bench for alu_mem
module tb_alu_mem;
  import simple_processor_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        re;
    logic        ill;
    logic        sticky;
    logic [15:0] ldc;
    logic [15:0] stc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  func_t       func = ADD;
  logic        we = 1'b0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] rd = '0;

  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        mem_re;
  logic        illegal;
  logic        illegal_sticky;
  logic [15:0] ld_cnt;
  logic [15:0] st_cnt;

  logic [15:0] m_ld = '0;
  logic [15:0] m_st = '0;
  logic        m_sticky = 1'b0;
  logic        p_rst = 1'b0;
  logic        p_re = 1'b0;
  logic        p_we = 1'b0;
  logic        p_ill = 1'b0;

  always #5 clk = ~clk;

  alu_mem #(.CNT_WIDTH(16)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .func_i          (func),
    .rs1_data_i      (rs1),
    .rs2_data_i      (rs2),
    .rd_data_i       (rd),
    .we_i            (we),
    .mem_addr_o      (mem_addr),
    .mem_data_o      (mem_data),
    .mem_we_o        (mem_we),
    .mem_re_o        (mem_re),
    .illegal_o       (illegal),
    .illegal_sticky_o(illegal_sticky),
    .ld_cnt_o        (ld_cnt),
    .st_cnt_o        (st_cnt)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step(input func_t f, input logic w, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c, input logic r);
    exp_t e;
    @(posedge clk);
    if (!p_rst) begin
      m_ld = '0; m_st = '0; m_sticky = 1'b0;
    end else begin
      if (p_re)  m_ld++;
      if (p_we)  m_st++;
      if (p_ill) m_sticky = 1'b1;
    end
    #1;
    func = f; we = w; rs1 = a; rs2 = b; rd = c; rst_n = r;
    e.addr   = a;
    e.data   = (f == LOAD) ? c : ((f == STORE) ? b : 32'h0);
    e.we     = (f == STORE) && w;
    e.re     = (f == LOAD) && !w;
    e.ill    = ((f == LOAD) && w) || ((f == STORE) && !w);
    e.sticky = m_sticky;
    e.ldc    = m_ld;
    e.stc    = m_st;
    q.push_back(e);
    p_rst = r; p_re = e.re; p_we = e.we; p_ill = e.ill;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_data", mem_data, e.data);
        chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
        chk("mem_re", {31'b0, mem_re}, {31'b0, e.re});
        chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
        chk("illegal_sticky", {31'b0, illegal_sticky}, {31'b0, e.sticky});
        chk("ld_cnt", {16'b0, ld_cnt}, {16'b0, e.ldc});
        chk("st_cnt", {16'b0, st_cnt}, {16'b0, e.stc});
      end
    end
  end

  initial begin
    func_t ops[8];
    ops = '{ADD, SUB, AND, OR, XOR, SLL, SRL, SLT};

    // Reset state, then directed vectors
    step(ADD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(ADD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    step(STORE, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b1);
    step(LOAD, 1'b0, 32'h0000_2000, 32'h0, 32'h1234_5678, 1'b1);
    step(ADD, 1'b0, 32'h4, 32'h8, 32'hC, 1'b1);
    step(LOAD, 1'b1, 32'h0000_3000, 32'h5555_5555, 32'hCAFE_F00D, 1'b1);
    repeat (10) step(STORE, 1'b1, 32'h40, 32'h1111_2222, 32'h3333_4444, 1'b1);

    // Non-memory opcodes with live operands
    foreach (ops[i]) step(ops[i], i[0], 32'hA5A5_0000 + i, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1);
    foreach (ops[i]) step(ops[i], ~i[0], $urandom, $urandom, $urandom, 1'b1);

    // Random LOAD/STORE with random we_i
    repeat (2000) step(($urandom & 1) ? LOAD : STORE, 1'($urandom), $urandom, $urandom, $urandom, 1'b1);

    // Mid-stream reset
    step(LOAD, 1'b0, 32'h10, 32'h20, 32'h30, 1'b0);
    step(STORE, 1'b1, 32'h14, 32'h24, 32'h34, 1'b1);
    step(LOAD, 1'b0, 32'h18, 32'h28, 32'h38, 1'b1);
    step(ADD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Load counter wrap
    step(ADD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (65535) step(LOAD, 1'b0, 32'h100, 32'h0, 32'h77, 1'b1);
    step(ADD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("ld_cnt_max", {16'b0, ld_cnt}, 32'h0000_FFFF);
    step(LOAD, 1'b0, 32'h100, 32'h0, 32'h77, 1'b1);
    step(ADD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("ld_cnt_wrap", {16'b0, ld_cnt}, 32'h0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drain", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
